// File: rtl/core_seq_fsm.sv
// Instruction sequencer: fetches a word, decodes R-type ALU ops, and steps
// FETCH -> DECODE -> EXEC -> WB, with sticky illegal/fetch-timeout flags.
module core_seq_fsm #(
    parameter int data_width = 32,
    parameter int addr_width = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  imem_ack,
    input  logic [data_width-1:0] inst_in,
    output logic                  imem_req,
    output logic [data_width-1:0] ir_out,
    output logic                  pc_en,
    output logic                  regwrite,
    output logic [3:0]            alu_in,
    output logic [2:0]            state,
    output logic                  illegal,
    output logic                  fetch_err,
    output logic [31:0]           instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [data_width-1:0]   ir_q;
    logic [3:0]              wait_q;
    logic [3:0]              alu_q;
    logic                    legal_q;
    logic                    illegal_q;
    logic                    fetch_err_q;
    logic [31:0]             count_q;

    logic [6:0]              opcode;
    logic [2:0]              func3;
    logic [6:0]              func7;
    logic [addr_width-1:0]   rd;
    logic [3:0]              dec_alu;
    logic                    dec_legal;
    logic                    fetch_timeout;

    assign opcode = ir_q[6:0];
    assign func3  = ir_q[14:12];
    assign func7  = ir_q[31:25];
    assign rd     = ir_q[7 +: addr_width];

    // Only the R-type ALU opcode decodes; anything else retires as a NOP.
    always_comb begin
        dec_alu   = 4'b0000;
        dec_legal = 1'b0;
        if (opcode == 7'b0110011) begin
            if (func7 == 7'h00) begin
                dec_legal = 1'b1;
                case (func3)
                    3'd0:    dec_alu = 4'b0010;
                    3'd7:    dec_alu = 4'b0000;
                    3'd6:    dec_alu = 4'b0001;
                    3'd4:    dec_alu = 4'b0011;
                    3'd1:    dec_alu = 4'b0100;
                    3'd5:    dec_alu = 4'b0101;
                    default: dec_legal = 1'b0;
                endcase
            end else if (func7 == 7'h20 && func3 == 3'd0) begin
                dec_legal = 1'b1;
                dec_alu   = 4'b0110;
            end
        end
    end

    // 15th consecutive FETCH cycle without an ack gives up.
    assign fetch_timeout = (state_q == FETCH) && !imem_ack && (wait_q == 4'd14);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH: begin
                if (imem_ack)           state_d = DECODE;
                else if (fetch_timeout) state_d = HALT;
            end
            DECODE:  state_d = (ir_q == '0) ? HALT : EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = run ? FETCH : IDLE;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ir_q        <= '0;
            wait_q      <= 4'd0;
            alu_q       <= 4'd0;
            legal_q     <= 1'b0;
            illegal_q   <= 1'b0;
            fetch_err_q <= 1'b0;
            count_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q != FETCH && state_d == FETCH) begin
                wait_q <= 4'd0;
            end else if (state_q == FETCH && !imem_ack) begin
                wait_q <= wait_q + 4'd1;
            end
            if (state_q == FETCH && imem_ack) begin
                ir_q <= inst_in;
            end
            if (fetch_timeout) begin
                fetch_err_q <= 1'b1;
            end
            if (state_q == DECODE && ir_q != '0) begin
                alu_q   <= dec_alu;
                legal_q <= dec_legal;
                if (!dec_legal) illegal_q <= 1'b1;
            end
            if (state_q == WB) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // imem_req is a level request held for every FETCH cycle; the word is
    // taken on the first rising edge where imem_req and imem_ack are both 1.
    assign imem_req    = (state_q == FETCH);
    assign ir_out      = ir_q;
    assign pc_en       = (state_q == WB);
    assign regwrite    = (state_q == WB) && legal_q && (rd != '0);
    assign alu_in      = (state_q == EXEC || state_q == WB) ? alu_q : 4'b0000;
    assign state       = state_q;
    assign illegal     = illegal_q;
    assign fetch_err   = fetch_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_core_seq_fsm.sv
// Directed bench for core_seq_fsm: a table of instructions run back to back,
// plus hand-written sequences for timeout, halt, run drop and reset.
module tb_core_seq_fsm;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_ack;
    logic [31:0] inst_in;
    logic        imem_req;
    logic [31:0] ir_out;
    logic        pc_en;
    logic        regwrite;
    logic [3:0]  alu_in;
    logic [2:0]  state;
    logic        illegal;
    logic        fetch_err;
    logic [31:0] instr_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 0;
    logic        exp_ill = 0;
    logic [3:0]  exp_q[$];

    core_seq_fsm #(.data_width(32), .addr_width(5)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .inst_in(inst_in),
        .imem_req(imem_req), .ir_out(ir_out), .pc_en(pc_en), .regwrite(regwrite),
        .alu_in(alu_in), .state(state), .illegal(illegal), .fetch_err(fetch_err),
        .instr_count(instr_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        int          waits;
        logic [3:0]  alu;
        logic        rw;
        logic        ill;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; inst_in = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        exp_ill = 1'b0;
    endtask

    // Entered at a negedge with the DUT in FETCH; leaves it one cycle after WB.
    task automatic exec_instr(input vec_t v, input logic drop_run);
        logic [3:0] exp_alu;
        for (int w = 0; w < v.waits; w++) begin
            chk({v.name, " wait state"}, state, 3'd1);
            chk({v.name, " wait imem_req"}, imem_req, 1'b1);
            @(negedge clk);
        end
        imem_ack = 1'b1; inst_in = v.inst;
        exp_q.push_back(v.alu);
        @(negedge clk);
        imem_ack = 1'b0; inst_in = 32'hDEAD_BEEF;
        chk({v.name, " decode state"}, state, 3'd2);
        chk({v.name, " ir_out"}, ir_out, v.inst);
        chk({v.name, " decode alu_in"}, alu_in, 4'd0);
        @(negedge clk);
        exp_alu = exp_q.pop_front();
        chk({v.name, " exec state"}, state, 3'd3);
        chk({v.name, " exec alu_in"}, alu_in, exp_alu);
        chk({v.name, " exec pc_en"}, pc_en, 1'b0);
        if (drop_run) run = 1'b0;
        @(negedge clk);
        chk({v.name, " wb state"}, state, 3'd4);
        chk({v.name, " wb alu_in"}, alu_in, exp_alu);
        chk({v.name, " wb regwrite"}, regwrite, v.rw);
        chk({v.name, " wb pc_en"}, pc_en, 1'b1);
        @(negedge clk);
        exp_cnt = exp_cnt + 1;
        exp_ill = exp_ill | v.ill;
        chk({v.name, " instr_count"}, instr_count, exp_cnt);
        chk({v.name, " illegal"}, illegal, exp_ill);
        chk({v.name, " next state"}, state, run ? 3'd1 : 3'd0);
        chk({v.name, " post alu_in"}, alu_in, 4'd0);
        chk({v.name, " post pc_en"}, pc_en, 1'b0);
    endtask

    initial begin
        vec_t vecs[10];
        vec_t v;
        vecs[0] = '{"add",   32'h002081B3, 0, 4'b0010, 1'b1, 1'b0};
        vecs[1] = '{"sub0",  32'h40208033, 0, 4'b0110, 1'b0, 1'b0};
        vecs[2] = '{"and",   32'h0020F233, 1, 4'b0000, 1'b1, 1'b0};
        vecs[3] = '{"or",    32'h0020E2B3, 2, 4'b0001, 1'b1, 1'b0};
        vecs[4] = '{"xor",   32'h0020C333, 0, 4'b0011, 1'b1, 1'b0};
        vecs[5] = '{"addi",  32'h00000013, 3, 4'b0000, 1'b0, 1'b1};
        vecs[6] = '{"sll",   32'h002093B3, 0, 4'b0100, 1'b1, 1'b0};
        vecs[7] = '{"srl",   32'h0020D433, 1, 4'b0101, 1'b1, 1'b0};
        vecs[8] = '{"sra",   32'h4020D4B3, 0, 4'b0000, 1'b0, 1'b1};
        vecs[9] = '{"f7x3",  32'h4020F4B3, 0, 4'b0000, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("reset state", state, 3'd0);
        chk("reset imem_req", imem_req, 1'b0);
        chk("reset ir_out", ir_out, 32'd0);
        chk("reset count", instr_count, 32'd0);
        chk("reset flags", {illegal, fetch_err, pc_en, regwrite}, 4'd0);
        chk("reset alu_in", alu_in, 4'd0);

        // Idle ignores ack while run is low
        imem_ack = 1'b1; inst_in = 32'h1234_5678;
        @(negedge clk);
        chk("idle hold", state, 3'd0);
        chk("idle ack ignored", ir_out, 32'd0);
        imem_ack = 1'b0;

        // Table: back-to-back instructions with varying fetch waits
        run = 1'b1;
        @(negedge clk);
        chk("enter fetch", state, 3'd1);
        foreach (vecs[i]) exec_instr(vecs[i], 1'b0);

        // Run dropped during EXEC: WB still completes, then IDLE
        v = '{"drop", 32'h002081B3, 0, 4'b0010, 1'b1, 1'b0};
        exec_instr(v, 1'b1);
        @(negedge clk);
        chk("drop idle stays", state, 3'd0);

        // Halt instruction: HALT after DECODE, not counted
        run = 1'b1;
        @(negedge clk);
        imem_ack = 1'b1; inst_in = 32'h0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("halt decode", state, 3'd2);
        @(negedge clk);
        chk("halt state", state, 3'd5);
        chk("halt pc_en", pc_en, 1'b0);
        @(negedge clk);
        chk("halt absorbing", state, 3'd5);
        chk("halt count", instr_count, exp_cnt);
        chk("halt imem_req", imem_req, 1'b0);

        // Fetch timeout
        do_reset();
        run = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 14; c++) @(negedge clk);
        chk("timeout 14 still fetch", state, 3'd1);
        chk("timeout 14 no err", fetch_err, 1'b0);
        @(negedge clk);
        chk("timeout halt", state, 3'd5);
        chk("timeout fetch_err", fetch_err, 1'b1);
        imem_ack = 1'b1; inst_in = 32'h002081B3;
        @(negedge clk);
        @(negedge clk);
        chk("halt ack ignored state", state, 3'd5);
        chk("halt ack ignored ir", ir_out, 32'd0);
        chk("halt imem_req off", imem_req, 1'b0);
        imem_ack = 1'b0;
        do_reset();
        chk("post-halt reset state", state, 3'd0);
        chk("post-halt reset flags", {illegal, fetch_err}, 2'd0);

        // Waits restart per fetch: 10 waits twice must not time out
        run = 1'b1;
        @(negedge clk);
        v = '{"wait10a", 32'h002081B3, 10, 4'b0010, 1'b1, 1'b0};
        exec_instr(v, 1'b0);
        v = '{"wait10b", 32'h40208033, 10, 4'b0110, 1'b0, 1'b0};
        exec_instr(v, 1'b0);
        chk("no spurious fetch_err", fetch_err, 1'b0);

        // Reset in FETCH with ack the same cycle wins
        rst = 1'b1; imem_ack = 1'b1; inst_in = 32'hCAFE_F00D;
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b0; run = 1'b0;
        chk("rst vs ack state", state, 3'd0);
        chk("rst vs ack ir_out", ir_out, 32'd0);
        chk("rst vs ack count", instr_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/core_seq_fsm.md
CORE_SEQ_FSM -- requirements
Module: core_seq_fsm

Interface
REQ-001 The block SHALL have parameter data_width, default 32, meaning instruction/word width.
REQ-002 The block SHALL have parameter addr_width, default 5, meaning register-address width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port run  input  1  level enable; start and continue sequencing.
REQ-006 The block SHALL have port imem_ack  input  1  instruction memory data-valid.
REQ-007 The block SHALL have port inst_in  input  data_width  instruction word from memory, sampled when imem_ack=1 in FETCH.
REQ-008 The block SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 The block SHALL have port ir_out  output  data_width  latched instruction register to the decoder.
REQ-010 The block SHALL have port pc_en  output  1  one-cycle PC advance strobe.
REQ-011 The block SHALL have port regwrite  output  1  register-file write enable.
REQ-012 The block SHALL have port alu_in  output  4  ALU operation select.
REQ-013 The block SHALL have port state  output  3  current FSM state code.
REQ-014 The block SHALL have port illegal  output  1  sticky flag; an unsupported opcode or func was seen.
REQ-015 The block SHALL have port fetch_err  output  1  sticky flag; fetch timeout.
REQ-016 The block SHALL have port instr_count  output  32  count of retired instructions.

Function
REQ-017 The FSM SHALL have states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4 and HALT=5; codes 6 and 7 SHALL go to HALT on the next cycle.
REQ-018 IDLE: if run=1, go to FETCH next cycle; otherwise stay in IDLE.
REQ-019 FETCH: imem_req=1 every cycle in this state.
  - imem_ack=1: load inst_in into ir_out and go to DECODE.
  - No ack: an internal 4-bit wait counter increments.
REQ-020 If the wait counter reaches 15 with no ack, go to HALT and set fetch_err; the counter SHALL clear on entry to FETCH.
REQ-021 DECODE, using ir_out fields opcode[6:0], func3[14:12], func7[31:25] and rd[11:7]:
  - ir_out==0: go to HALT; this is the halt instruction and is not counted.
  - Otherwise: go to EXEC.
REQ-022 ALU select SHALL be decoded only for opcode 0110011.
  - func7=0x00: f3=0 gives 0010 (ADD), f3=7 gives 0000 (AND), f3=6 gives 0001 (OR), f3=4 gives 0011 (XOR), f3=1 gives 0100 (SLL), f3=5 gives 0101 (SRL).
  - func7=0x20, f3=0: gives 0110 (SUB).
  - Any other combination or opcode: illegal; set the illegal flag and use alu_in=0000.
REQ-023 EXEC: alu_in SHALL hold the decoded value; the value SHALL stay stable from EXEC through WB and be 0000 in all other states.
REQ-024 WB: the block SHALL assert regwrite for one cycle only if the instruction is legal and rd!=0.
REQ-025 WB: the block SHALL pulse pc_en and increment instr_count, including for illegal instructions, which retire as NOPs.
REQ-026 WB exit: if run=1, go to FETCH; if run=0, go to IDLE.
REQ-027 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes through WB.
REQ-028 HALT SHALL be absorbing and exited only by rst; in HALT, imem_req=0, pc_en=0 and regwrite=0.
REQ-029 Minimum latency SHALL be 4 cycles per instruction (FETCH, DECODE, EXEC, WB) when imem_ack=1 in the first FETCH cycle; each extra wait cycle adds 1.
REQ-030 instr_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 imem_ack outside FETCH SHALL be ignored.
REQ-032 pc_en and regwrite SHALL never be asserted outside WB.

Reset
REQ-033 rst=1 at a clock edge SHALL, from any state including mid-fetch, set:
  - state=IDLE;
  - imem_req, pc_en, regwrite, illegal and fetch_err to 0;
  - alu_in=0000, ir_out=0, instr_count=0 and the wait counter to 0.
REQ-034 rst SHALL take priority over run and imem_ack in the same cycle.

Verification
REQ-035 Reset then run=1, then ack on the first FETCH cycle with inst 0x002081B3 (add x3,x1,x2) -> in WB: regwrite=1, alu_in=0010 and pc_en=1; instr_count=1 after exactly 4 cycles; FSM back in FETCH.
REQ-036 Inst 0x40208033 (sub, rd=x0) -> alu_in=0110 in EXEC/WB, regwrite=0, pc_en=1, instr_count increments.
REQ-037 Inst 0x00000013 (opcode 0010011) -> illegal=1, regwrite=0, pc_en=1; sequencing continues; illegal stays 1 until rst.
REQ-038 imem_ack withheld for 15 FETCH cycles -> HALT (state=5) and fetch_err=1; imem_ack=1 afterwards causes no change; rst returns state=0 and all flags to 0.
REQ-039 Inst 0x00000000 -> HALT after DECODE; instr_count unchanged; no pc_en pulse.
REQ-040 run dropped during EXEC -> WB completes (pc_en=1), then IDLE; rst asserted in FETCH with ack in the same cycle -> IDLE, ir_out=0.
